// File: rtl/counter_timer_arbiter.sv
// -----------------------------------------------------------------------------
// counter_timer_arbiter
//
// Shares one CW-bit interval counter among N_REQ requesters with round-robin
// arbitration. A granted requester gets the counter from 0 for max(dur,1)
// cycles, then a one-cycle done pulse (or an abort pulse if it withdrew its
// request early). The block owns the counter's clear and enable.
//
// Ports
//   clk      in   1          system clock, rising edge
//   rst      in   1          asynchronous, active-low reset
//   req      in   N_REQ      level request, one bit per requester
//   dur      in   N_REQ*CW   per-requester duration, requester i at [i*CW +: CW]
//   gnt      out  N_REQ      one-hot grant, held through RUN and DONE
//   busy     out  1          high in RUN and DONE
//   cnt      out  CW         interval counter value
//   done     out  1          one-cycle completion pulse
//   abort    out  1          one-cycle pulse, interval ended by req withdrawal
//   done_id  out  IW         requester that finished/aborted, valid with done/abort
// -----------------------------------------------------------------------------
module counter_timer_arbiter #(
   parameter  int N_REQ = 4,
   parameter  int CW    = 5,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*CW-1:0] dur,
   output logic [N_REQ-1:0]    gnt,
   output logic                busy,
   output logic [CW-1:0]       cnt,
   output logic                done,
   output logic                abort,
   output logic [IW-1:0]       done_id
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] sel;
   logic [CW-1:0] dlat;

   // Round-robin scan result for the current IDLE cycle
   logic          found;
   logic [IW-1:0] pick;
   logic [IW:0]   scan;
   logic [CW-1:0] pick_dur;

   // Scan req starting at rr_ptr and wrapping past N_REQ-1; the extra bit in
   // scan lets the wrap work for non-power-of-two N_REQ.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise the paths that skip an assignment infer a latch.
      found    = 1'b0;
      pick     = '0;
      scan     = '0;
      pick_dur = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (IW+1)'(k);
         if (scan >= (IW+1)'(N_REQ)) scan = scan - (IW+1)'(N_REQ);
         if (!found && req[scan[IW-1:0]]) begin
            found = 1'b1;
            pick  = scan[IW-1:0];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == IW'(i)) pick_dur = dur[i*CW +: CW];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         sel     <= '0;
         dlat    <= '0;
         gnt     <= '0;
         busy    <= 1'b0;
         cnt     <= '0;
         done    <= 1'b0;
         abort   <= 1'b0;
         done_id <= '0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  sel   <= pick;
                  // A zero duration still yields a one-cycle interval.
                  dlat  <= (pick_dur == '0) ? CW'(1) : pick_dur;
                  gnt   <= N_REQ'(1) << pick;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // Withdrawal wins over completion; cnt holds on either exit.
               if (!req[sel]) begin
                  abort   <= 1'b1;
                  done_id <= sel;
                  state   <= DONE;
               end else if (cnt == dlat - CW'(1)) begin
                  done    <= 1'b1;
                  done_id <= sel;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               rr_ptr <= (sel == IW'(N_REQ-1)) ? '0 : sel + IW'(1);
               gnt    <= '0;
               busy   <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_timer_arbiter
//
// Directed scenarios plus a randomized run checked against a transaction-level
// model (round-robin pick by index arithmetic, interval length max(dur,1)).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_timer_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [19:0] dur;
   logic [3:0]  gnt;
   logic        busy;
   logic [4:0]  cnt;
   logic        done;
   logic        abort;
   logic [1:0]  done_id;

   int tests_run    = 0;
   int tests_failed = 0;

   counter_timer_arbiter #(.N_REQ(4), .CW(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .dur     (dur),
      .gnt     (gnt),
      .busy    (busy),
      .cnt     (cnt),
      .done    (done),
      .abort   (abort),
      .done_id (done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      dur = '0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
   endtask

   function automatic logic [3:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   // Reference round-robin: first set bit at or after ptr, wrapping.
   function automatic int rr_pick(input logic [3:0] m, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (m[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      dur = '0;
      #2;
      rst = 1'b0;
      req = 4'b1111;
      dur = 20'($urandom);
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if ({gnt, busy, cnt, done, abort, done_id} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset c=%0d got gnt=%b busy=%b cnt=%0d done=%b abort=%b id=%0d exp all 0",
                     c, gnt, busy, cnt, done, abort, done_id);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      dur = 20'($urandom);
      dur[10 +: 5] = 5'd6;
      req = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         tick();
         tests_run++;
         if ({gnt, busy, cnt, done, abort} !== {4'b0100, 1'b1, 5'(k), 2'b00}) begin
            tests_failed++;
            $display("FAIL single_run k=%0d got gnt=%b busy=%b cnt=%0d done=%b abort=%b exp gnt=0100 busy=1 cnt=%0d",
                     k, gnt, busy, cnt, done, abort, k);
         end
      end
      tick();
      tests_run++;
      if ({gnt, done, abort, done_id, cnt} !== {4'b0100, 1'b1, 1'b0, 2'd2, 5'd5}) begin
         tests_failed++;
         $display("FAIL single_done got gnt=%b done=%b abort=%b id=%0d cnt=%0d exp gnt=0100 done=1 abort=0 id=2 cnt=5",
                  gnt, done, abort, done_id, cnt);
      end
      req = '0;
      tick();
      tests_run++;
      if ({gnt, busy, cnt, done, abort} !== 12'd0) begin
         tests_failed++;
         $display("FAIL single_idle got gnt=%b busy=%b cnt=%0d done=%b abort=%b exp all 0",
                  gnt, busy, cnt, done, abort);
      end
      // Pointer now at 3: requester 3 must beat requester 0.
      req = 4'b1001;
      tick();
      tests_run++;
      if (gnt !== 4'b1000) begin
         tests_failed++;
         $display("FAIL single_rr_ptr got gnt=%b exp 1000", gnt);
      end
   endtask

   task automatic test_round_robin();
      int          phase;
      int          idx;
      logic [3:0]  exp_gnt;
      do_reset();
      dur = {4{5'd2}};
      req = 4'b1111;
      for (int c = 1; c <= 20; c++) begin
         tick();
         phase   = (c - 1) % 4;
         idx     = ((c - 1) / 4) % 4;
         exp_gnt = (phase < 3) ? oh(idx) : 4'b0000;
         tests_run++;
         if ({gnt, done} !== {exp_gnt, (phase == 2)}) begin
            tests_failed++;
            $display("FAIL round_robin c=%0d got gnt=%b done=%b exp gnt=%b done=%b",
                     c, gnt, done, exp_gnt, (phase == 2));
         end
      end
      req = '0;
   endtask

   task automatic test_dur_bounds();
      int ids[2]  = '{0, 3};
      int durs[2] = '{0, 31};
      int de;
      do_reset();
      for (int n = 0; n < 2; n++) begin
         de  = (durs[n] == 0) ? 1 : durs[n];
         dur = 20'($urandom);
         dur[ids[n]*5 +: 5] = 5'(durs[n]);
         req = oh(ids[n]);
         for (int k = 0; k < de; k++) begin
            tick();
            tests_run++;
            if ({gnt, busy, cnt, done} !== {oh(ids[n]), 1'b1, 5'(k), 1'b0}) begin
               tests_failed++;
               $display("FAIL bounds_run dur=%0d k=%0d got gnt=%b busy=%b cnt=%0d done=%b exp cnt=%0d",
                        durs[n], k, gnt, busy, cnt, done, k);
            end
         end
         tick();
         tests_run++;
         if ({gnt, done, abort, done_id, cnt} !== {oh(ids[n]), 1'b1, 1'b0, 2'(ids[n]), 5'(de - 1)}) begin
            tests_failed++;
            $display("FAIL bounds_done dur=%0d got gnt=%b done=%b abort=%b id=%0d cnt=%0d exp done=1 id=%0d cnt=%0d",
                     durs[n], gnt, done, abort, done_id, cnt, ids[n], de - 1);
         end
         req = '0;
         tick();
         tests_run++;
         if ({gnt, busy, cnt, done} !== 11'd0) begin
            tests_failed++;
            $display("FAIL bounds_idle dur=%0d got gnt=%b busy=%b cnt=%0d done=%b exp all 0",
                     durs[n], gnt, busy, cnt, done);
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      dur = 20'($urandom);
      dur[5 +: 5] = 5'd20;
      req = 4'b0010;
      for (int k = 0; k <= 4; k++) begin
         tick();
         tests_run++;
         if ({gnt, cnt, abort} !== {4'b0010, 5'(k), 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_run k=%0d got gnt=%b cnt=%0d abort=%b exp gnt=0010 cnt=%0d",
                     k, gnt, cnt, abort, k);
         end
      end
      req = '0;
      tick();
      tests_run++;
      if ({gnt, done, abort, done_id, cnt} !== {4'b0010, 1'b0, 1'b1, 2'd1, 5'd4}) begin
         tests_failed++;
         $display("FAIL abort_pulse got gnt=%b done=%b abort=%b id=%0d cnt=%0d exp gnt=0010 done=0 abort=1 id=1 cnt=4",
                  gnt, done, abort, done_id, cnt);
      end
      tick();
      tests_run++;
      if ({gnt, busy, done, abort} !== 7'd0) begin
         tests_failed++;
         $display("FAIL abort_idle got gnt=%b busy=%b done=%b abort=%b exp all 0", gnt, busy, done, abort);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      // One short interval for requester 0 moves the pointer to 1.
      dur = 20'($urandom);
      dur[0 +: 5] = 5'd1;
      req = 4'b0001;
      tick();
      tick();
      req = '0;
      tick();
      dur[10 +: 5] = 5'd15;
      req = 4'b1101;
      tick();
      tests_run++;
      if ({gnt, cnt} !== {4'b0100, 5'd0}) begin
         tests_failed++;
         $display("FAIL async_grant got gnt=%b cnt=%0d exp gnt=0100 cnt=0", gnt, cnt);
      end
      repeat (9) tick();
      tests_run++;
      if (cnt !== 5'd9) begin
         tests_failed++;
         $display("FAIL async_cnt got cnt=%0d exp 9", cnt);
      end
      #1;
      rst = 1'b0;
      #1;
      tests_run++;
      if ({gnt, busy, cnt, done, abort, done_id} !== 14'd0) begin
         tests_failed++;
         $display("FAIL async_immediate got gnt=%b busy=%b cnt=%0d done=%b abort=%b id=%0d exp all 0",
                  gnt, busy, cnt, done, abort, done_id);
      end
      tick();
      tests_run++;
      if ({gnt, busy, cnt, done, abort, done_id} !== 14'd0) begin
         tests_failed++;
         $display("FAIL async_held got gnt=%b busy=%b cnt=%0d done=%b abort=%b id=%0d exp all 0",
                  gnt, busy, cnt, done, abort, done_id);
      end
      rst = 1'b1;
      tick();
      tests_run++;
      if ({gnt, done, abort} !== {4'b0001, 2'b00}) begin
         tests_failed++;
         $display("FAIL async_first_grant got gnt=%b done=%b abort=%b exp gnt=0001 done=0 abort=0",
                  gnt, done, abort);
      end
   endtask

   task automatic test_random();
      int         rr;
      int         w;
      int         d;
      int         de;
      int         abort_at;
      int         k;
      bit         aborted;
      logic [3:0] pend;
      do_reset();
      rr   = 0;
      pend = '0;
      for (int n = 0; n < 40; n++) begin
         if (pend == 4'b0000 || $urandom_range(0, 1) == 1) pend = pend | 4'($urandom_range(1, 15));
         dur      = 20'($urandom);
         req      = pend;
         w        = rr_pick(pend, rr);
         d        = int'(dur[w*5 +: 5]);
         de       = (d == 0) ? 1 : d;
         abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, de - 1)) : -1;
         aborted  = 1'b0;
         k        = 0;
         tick();
         while (1) begin
            tests_run++;
            if ({gnt, busy, cnt, done, abort} !== {oh(w), 1'b1, 5'(k), 2'b00}) begin
               tests_failed++;
               $display("FAIL random_run n=%0d k=%0d got gnt=%b busy=%b cnt=%0d done=%b abort=%b exp gnt=%b cnt=%0d",
                        n, k, gnt, busy, cnt, done, abort, oh(w), k);
            end
            if (k == abort_at) begin
               pend[w] = 1'b0;
               req     = pend;
               aborted = 1'b1;
            end
            // Duration changes mid-interval must have no effect.
            dur = 20'($urandom);
            if (aborted || k == de - 1) break;
            tick();
            k++;
         end
         tick();
         tests_run++;
         if ({gnt, done, abort, done_id, cnt} !== {oh(w), !aborted, aborted, 2'(w), 5'(k)}) begin
            tests_failed++;
            $display("FAIL random_end n=%0d got gnt=%b done=%b abort=%b id=%0d cnt=%0d exp gnt=%b done=%b abort=%b id=%0d cnt=%0d",
                     n, gnt, done, abort, done_id, cnt, oh(w), !aborted, aborted, w, k);
         end
         // Most requesters release after done; some keep asking and rank last.
         if (!aborted && $urandom_range(0, 4) != 0) pend[w] = 1'b0;
         req = pend;
         rr  = (w + 1) % 4;
         tick();
         tests_run++;
         if ({gnt, busy, cnt, done, abort} !== 12'd0) begin
            tests_failed++;
            $display("FAIL random_idle n=%0d got gnt=%b busy=%b cnt=%0d done=%b abort=%b exp all 0",
                     n, gnt, busy, cnt, done, abort);
         end
      end
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      dur = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_dur_bounds();
      test_abort();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
